decode_stage: RTL and testbench

- Registered, handshaked successor to the combinational main decoder in the RISC-V pipeline; sits between the fetch and execute stages.
- Accepts one 32-bit instruction per cycle (valid/ready) and decodes opcode/funct3/funct7 into a control bundle plus register indices.
- Presents the bundle one cycle later through an output valid/ready register.
- Adds behaviour the old decoder lacks: branch decode, a timed pause FSM, an illegal-opcode trap instead of a simulation print, and flush.

---
 rtl/decode_pkg.sv | 46 ++++
 rtl/decode_ctrl_comb.sv | 78 +++++++
 rtl/decode_stage.sv | 145 ++++++++++++++
 tb/tb_decode_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared constants and the control bundle for the decode stage.
// DECODE_MEXT_EN adds the muldiv bit to ctrl_t for RV32M decode.
package decode_pkg;

  localparam logic [6:0] OP_PAUSE  = 7'b0001111;
  localparam logic [6:0] OP_IMMALU = 7'b0010011;
  localparam logic [6:0] OP_REGALU = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] IT_RTYPE = 3'd0;
  localparam logic [2:0] IT_ITYPE = 3'd1;
  localparam logic [2:0] IT_STYPE = 3'd2;
  localparam logic [2:0] IT_BTYPE = 3'd3;
  localparam logic [2:0] IT_JTYPE = 3'd4;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_PAUSE_WAIT = 2'd1,
    ST_TRAP       = 2'd2
  } state_e;

  typedef struct packed {
    logic       memtoreg;
    logic       memwrite;
    logic       alusrcimm;
    logic       writesreg;
    logic       readsreg;
    logic       jump;
    logic       branch;
    logic       pause;
    logic       illegal;
`ifdef DECODE_MEXT_EN
    logic       muldiv;
`endif
    logic [3:0] aluop;
    logic [2:0] itype;
  } ctrl_t;

endpackage

// File: rtl/decode_ctrl_comb.sv
// Combinational opcode/funct to control-bundle table.
// DECODE_MEXT_EN: REGALU with funct7=0000001 decodes as RV32M.
module decode_ctrl_comb
  import decode_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o
);

`ifndef DECODE_MEXT_EN
  logic unused_funct7;
  assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};
`endif

  always_comb begin
    ctrl_o       = '0;
    ctrl_o.aluop = ALU_ADD;
    ctrl_o.itype = IT_RTYPE;
    case (opcode_i)
      OP_IMMALU: begin
        ctrl_o.writesreg = 1'b1;
        ctrl_o.readsreg  = 1'b1;
        ctrl_o.alusrcimm = 1'b1;
        ctrl_o.itype     = IT_ITYPE;
        // Only shifts-right carry an arithmetic/logical selector in funct7
        ctrl_o.aluop     = (funct3_i == 3'b101) ? {funct7_i[5], 3'b101}
                                                : {1'b0, funct3_i};
      end
      OP_REGALU: begin
        ctrl_o.writesreg = 1'b1;
        ctrl_o.readsreg  = 1'b1;
        ctrl_o.aluop     = {funct7_i[5], funct3_i};
`ifdef DECODE_MEXT_EN
        if (funct7_i == 7'b0000001) begin
          ctrl_o.muldiv = 1'b1;
          ctrl_o.aluop  = {1'b0, funct3_i};
        end
`endif
      end
      OP_LOAD: begin
        ctrl_o.memtoreg  = 1'b1;
        ctrl_o.writesreg = 1'b1;
        ctrl_o.readsreg  = 1'b1;
        ctrl_o.alusrcimm = 1'b1;
        ctrl_o.itype     = IT_ITYPE;
      end
      OP_STORE: begin
        ctrl_o.memwrite  = 1'b1;
        ctrl_o.readsreg  = 1'b1;
        ctrl_o.alusrcimm = 1'b1;
        ctrl_o.itype     = IT_STYPE;
      end
      OP_JAL: begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.writesreg = 1'b1;
        ctrl_o.itype     = IT_JTYPE;
      end
      OP_JALR: begin
        ctrl_o.jump      = 1'b1;
        ctrl_o.writesreg = 1'b1;
        ctrl_o.readsreg  = 1'b1;
        ctrl_o.alusrcimm = 1'b1;
        ctrl_o.itype     = IT_ITYPE;
      end
      OP_BRANCH: begin
        ctrl_o.branch   = 1'b1;
        ctrl_o.readsreg = 1'b1;
        ctrl_o.itype    = IT_BTYPE;
        ctrl_o.aluop    = ALU_SUB;
      end
      OP_PAUSE: ctrl_o.pause = 1'b1;
      default:  ctrl_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready input, output register, pause/trap FSM.
// DECODE_MEXT_EN adds the out_muldiv port.
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int PAUSE_CYCLES = 4,
  parameter int CNT_W        = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic            out_memtoreg,
  output logic            out_memwrite,
  output logic            out_alusrcimm,
  output logic            out_writesreg,
  output logic            out_readsreg,
  output logic            out_jump,
  output logic            out_branch,
  output logic            out_pause,
  output logic            out_illegal,
  output logic [3:0]      out_aluop,
  output logic [2:0]      out_itype,
`ifdef DECODE_MEXT_EN
  output logic            out_muldiv,
`endif
  output logic            busy,
  output logic [1:0]      dbg_state
);

  // Handshake: a transfer happens on any edge where in_valid && in_ready.
  // out_valid holds with stable contents until out_ready; flush overrides both.
  state_e          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            valid_q, valid_d;
  ctrl_t           ctrl_q, ctrl_d, ctrl_dec;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [14:0]     regs_q, regs_d;
  logic            accept;

  decode_ctrl_comb u_ctrl (
    .opcode_i (in_instr[6:0]),
    .funct3_i (in_instr[14:12]),
    .funct7_i (in_instr[31:25]),
    .ctrl_o   (ctrl_dec)
  );

  assign in_ready = (state_q == ST_RUN) && !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    pc_d    = pc_q;
    regs_d  = regs_q;
    if (flush) begin
      state_d = ST_RUN;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      if (accept) begin
        valid_d = 1'b1;
        ctrl_d  = ctrl_dec;
        pc_d    = in_pc;
        regs_d  = {in_instr[11:7], in_instr[19:15], in_instr[24:20]};
      end else if (out_ready) begin
        valid_d = 1'b0;
      end
      case (state_q)
        ST_RUN: begin
          if (accept && ctrl_dec.pause) begin
            state_d = ST_PAUSE_WAIT;
            cnt_d   = CNT_W'(PAUSE_CYCLES);
          end else if (accept && ctrl_dec.illegal) begin
            state_d = ST_TRAP;
          end
        end
        ST_PAUSE_WAIT: begin
          // Leave on the edge where the counter reaches zero
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_TRAP: state_d = ST_TRAP;
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      valid_q      <= 1'b0;
      ctrl_q       <= '0;
      pc_q         <= '0;
      regs_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      valid_q      <= valid_d;
      ctrl_q       <= ctrl_d;
      pc_q         <= pc_d;
      regs_q       <= regs_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = pc_q;
  assign out_rd        = regs_q[14:10];
  assign out_rs1       = regs_q[9:5];
  assign out_rs2       = regs_q[4:0];
  assign out_memtoreg  = ctrl_q.memtoreg;
  assign out_memwrite  = ctrl_q.memwrite;
  assign out_alusrcimm = ctrl_q.alusrcimm;
  assign out_writesreg = ctrl_q.writesreg;
  assign out_readsreg  = ctrl_q.readsreg;
  assign out_jump      = ctrl_q.jump;
  assign out_branch    = ctrl_q.branch;
  assign out_pause     = ctrl_q.pause;
  assign out_illegal   = ctrl_q.illegal;
  assign out_aluop     = ctrl_q.aluop;
  assign out_itype     = ctrl_q.itype;
`ifdef DECODE_MEXT_EN
  assign out_muldiv    = ctrl_q.muldiv;
`endif
  assign busy          = (state_q != ST_RUN);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: handshake, decode table, pause, trap, flush, reset.
module tb_decode_stage;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic        out_memtoreg, out_memwrite, out_alusrcimm, out_writesreg, out_readsreg;
  logic        out_jump, out_branch, out_pause, out_illegal, busy;
  logic [3:0]  out_aluop;
  logic [2:0]  out_itype;
  logic [1:0]  dbg_state;
`ifdef DECODE_MEXT_EN
  logic        out_muldiv;
`endif
  logic [15:0] ctrl_obs;
  int checks = 0;
  int passed = 0;

  decode_stage #(.XLEN(32), .PAUSE_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_memtoreg(out_memtoreg), .out_memwrite(out_memwrite),
    .out_alusrcimm(out_alusrcimm), .out_writesreg(out_writesreg),
    .out_readsreg(out_readsreg), .out_jump(out_jump), .out_branch(out_branch),
    .out_pause(out_pause), .out_illegal(out_illegal),
    .out_aluop(out_aluop), .out_itype(out_itype),
`ifdef DECODE_MEXT_EN
    .out_muldiv(out_muldiv),
`endif
    .busy(busy), .dbg_state(dbg_state)
  );

  // {memtoreg,memwrite,alusrcimm,writesreg,readsreg,jump,branch,pause,illegal,aluop,itype}
  assign ctrl_obs = {out_memtoreg, out_memwrite, out_alusrcimm, out_writesreg, out_readsreg,
                     out_jump, out_branch, out_pause, out_illegal, out_aluop, out_itype};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({out_valid, ctrl_obs, out_pc, out_rd, out_rs1, out_rs2, busy} !== '0) begin
      $display("FAIL reset_outputs got valid=%0b ctrl=%h pc=%h busy=%0b exp all 0",
               out_valid, ctrl_obs, out_pc, busy);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({in_ready, busy, dbg_state} !== 4'b1000) begin
      $display("FAIL reset_ready got ready=%0b busy=%0b st=%0d exp 1/0/0", in_ready, busy, dbg_state);
    end else passed++;
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100; out_ready = 1'b1;
    tick();
    checks++;
    if ({out_valid, out_writesreg, out_aluop, out_rd, out_pc} !== {1'b1, 1'b1, 4'b0000, 5'd1, 32'h100}) begin
      $display("FAIL b2b_addi got v=%0b w=%0b alu=%b rd=%0d pc=%h exp 1 1 0000 1 100",
               out_valid, out_writesreg, out_aluop, out_rd, out_pc);
    end else passed++;
    in_instr = 32'h002081B3; in_pc = 32'h104;
    tick();
    checks++;
    if ({out_valid, out_writesreg, out_aluop, out_rd, out_rs1, out_rs2, out_pc}
        !== {1'b1, 1'b1, 4'b0000, 5'd3, 5'd1, 5'd2, 32'h104}) begin
      $display("FAIL b2b_add got v=%0b w=%0b alu=%b rd=%0d rs1=%0d rs2=%0d pc=%h exp 1 1 0000 3 1 2 104",
               out_valid, out_writesreg, out_aluop, out_rd, out_rs1, out_rs2, out_pc);
    end else passed++;
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL b2b_drain got valid=%0b exp 0", out_valid);
    else passed++;
  endtask

  task automatic test_backpressure();
    in_valid = 1'b1; in_instr = 32'h40208133; in_pc = 32'h200; out_ready = 1'b0;
    tick();
    in_instr = 32'h00500093; in_pc = 32'h204;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({in_ready, out_valid, out_aluop, out_rd, out_pc} !== {1'b0, 1'b1, 4'b1000, 5'd2, 32'h200}) begin
        $display("FAIL bp_hold%0d got rdy=%0b v=%0b alu=%b rd=%0d pc=%h exp 0 1 1000 2 200",
                 i, in_ready, out_valid, out_aluop, out_rd, out_pc);
      end else passed++;
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b11) $display("FAIL bp_release got rdy=%0b v=%0b exp 1 1", in_ready, out_valid);
    else passed++;
    tick();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL bp_drain got valid=%0b exp 0", out_valid);
    else passed++;
  endtask

  task automatic test_decode_table();
    logic [31:0] instr [8];
    logic [15:0] exp_c [8];
    instr = '{32'h4050D093, 32'h0000A103, 32'h0020A023, 32'h008000EF,
              32'h000100E7, 32'h0020C0B3, 32'h4020D0B3, 32'h0FF0F093};
    exp_c = '{16'h3869, 16'hB801, 16'h6802, 16'h1404,
              16'h3C01, 16'h1820, 16'h1868, 16'h3839};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_instr = instr[i]; in_pc = 32'h300 + 32'(i * 4);
      tick();
      checks++;
      if ({out_valid, ctrl_obs} !== {1'b1, exp_c[i]}) begin
        $display("FAIL table%0d instr=%h got v=%0b ctrl=%h exp v=1 ctrl=%h",
                 i, instr[i], out_valid, ctrl_obs, exp_c[i]);
      end else passed++;
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_pause();
    int stalled;
    bit done;
    stalled = 0;
    done = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h0000000F; in_pc = 32'h400;
    tick();
    checks++;
    if ({out_valid, ctrl_obs, busy} !== {1'b1, 16'h0100, 1'b1}) begin
      $display("FAIL pause_issue got v=%0b ctrl=%h busy=%0b exp 1 0100 1", out_valid, ctrl_obs, busy);
    end else passed++;
    in_instr = 32'h00500093; in_pc = 32'h404;
    for (int i = 0; i < 20 && !done; i++) begin
      if (in_ready) done = 1'b1;
      else begin
        stalled++;
        tick();
      end
    end
    checks++;
    if (!done || stalled != 4) $display("FAIL pause_stall got %0d stalled cycles (done=%0b) exp 4", stalled, done);
    else passed++;
    tick();
    checks++;
    if ({out_valid, out_pause, out_rd, busy, out_pc} !== {1'b1, 1'b0, 5'd1, 1'b0, 32'h404}) begin
      $display("FAIL pause_resume got v=%0b p=%0b rd=%0d busy=%0b pc=%h exp 1 0 1 0 404",
               out_valid, out_pause, out_rd, busy, out_pc);
    end else passed++;
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_illegal_trap();
    int early;
    early = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h0000007F; in_pc = 32'h500;
    tick();
    checks++;
    if ({out_valid, ctrl_obs, busy, dbg_state} !== {1'b1, 16'h0080, 1'b1, 2'd2}) begin
      $display("FAIL trap_issue got v=%0b ctrl=%h busy=%0b st=%0d exp 1 0080 1 2",
               out_valid, ctrl_obs, busy, dbg_state);
    end else passed++;
    in_instr = 32'h00500093;
    for (int i = 0; i < 10; i++) begin
      if (in_ready !== 1'b0) early++;
      tick();
    end
    checks++;
    if (early != 0) $display("FAIL trap_hold got %0d ready cycles exp 0", early);
    else passed++;
    in_valid = 1'b0; flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL trap_flush_cycle got rdy=%0b exp 0", in_ready);
    else passed++;
    tick();
    flush = 1'b0;
    #1;
    checks++;
    if ({in_ready, busy, out_valid, dbg_state} !== 5'b10000) begin
      $display("FAIL trap_exit got rdy=%0b busy=%0b v=%0b st=%0d exp 1 0 0 0", in_ready, busy, out_valid, dbg_state);
    end else passed++;
  endtask

  task automatic test_branch_flush();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00208463; in_pc = 32'h600;
    tick();
    checks++;
    if ({out_valid, ctrl_obs, out_rd, out_rs1, out_rs2} !== {1'b1, 16'h0A43, 5'd8, 5'd1, 5'd2}) begin
      $display("FAIL beq_decode got v=%0b ctrl=%h rd=%0d rs1=%0d rs2=%0d exp 1 0a43 8 1 2",
               out_valid, ctrl_obs, out_rd, out_rs1, out_rs2);
    end else passed++;
    in_instr = 32'h00500093; in_pc = 32'h604; flush = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL flush_ready got rdy=%0b exp 0", in_ready);
    else passed++;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_kill got valid=%0b exp 0", out_valid);
    else passed++;
    tick();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_no_bundle got valid=%0b exp 0", out_valid);
    else passed++;
  endtask

  task automatic test_reset_mid_pause();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h0000000F; in_pc = 32'h700;
    tick();
    in_valid = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1) $display("FAIL rst_pause_busy got busy=%0b exp 1", busy);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, ctrl_obs, out_pc, out_rd, busy, in_ready} !== {1'b0, 16'h0000, 32'h0, 5'd0, 1'b0, 1'b1}) begin
      $display("FAIL rst_async got v=%0b ctrl=%h pc=%h busy=%0b rdy=%0b exp 0 0000 0 0 1",
               out_valid, ctrl_obs, out_pc, busy, in_ready);
    end else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({in_ready, busy, dbg_state} !== 4'b1000) begin
      $display("FAIL rst_release got rdy=%0b busy=%0b st=%0d exp 1 0 0", in_ready, busy, dbg_state);
    end else passed++;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_decode_table();
    test_pause();
    test_illegal_trap();
    test_branch_flush();
    test_reset_mid_pause();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
